// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// PC-source encodings, NOP word and fetch FSM types.
package mips_pkg;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcp4;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pcp4} holding slot for a response
// that lands while the IF/ID register is stalled.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       load,
  input  logic       unload,
  input  fetch_pkt_t din,
  output logic       full,
  output fetch_pkt_t dout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs one outstanding imem fetch
// and hands {inst, PC+4} to the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        keep,
  input  logic [1:0]  pc_source,
  input  logic [31:0] pc_branch,
  input  logic [31:0] pc_jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pcp4_out,
  output logic [31:0] pc_out
);

  import mips_pkg::*;

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [31:0] pc;
  logic [31:0] target;
  logic        kill;
  logic        redirect;
  logic        fire;
  logic        resp;
  logic        room;
  logic        skid_full;
  logic        skid_load;
  logic        skid_unload;
  logic        skid_full_nxt;
  fetch_pkt_t  skid_q;
  fetch_pkt_t  resp_pkt;

  assign redirect = (pc_source != PC_SRC_SEQ);
  assign fire     = imem_req && imem_gnt;
  assign pc_out   = pc;

  always_comb begin
    target = pc + 32'd4;
    unique case (1'b1)
      pc_source == PC_SRC_BRANCH: target = pc_branch;
      pc_source[1]:               target = pc_jump;
      default:                    target = pc + 32'd4;
    endcase
  end

  // In WAIT the PC has already stepped past the outstanding word,
  // so it is exactly that word's PC+4.
  assign resp = (state == WAIT) && imem_rvalid
             && !kill && !redirect;
  assign resp_pkt = '{inst: imem_rdata, pcp4: pc};

  assign skid_unload = !redirect && !keep && skid_full;
  assign skid_load   = resp && keep && inst_valid;
  assign skid_full_nxt = !redirect
    && ((skid_full && !skid_unload) || skid_load);
  assign room = !skid_full_nxt;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (redirect),
    .load   (skid_load),
    .unload (skid_unload),
    .din    (resp_pkt),
    .full   (skid_full),
    .dout   (skid_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = ISSUE;
      ISSUE: begin
        if (skid_full)     state_nxt = HOLD;
        else if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)
          state_nxt = room ? ISSUE : HOLD;
      end
      HOLD: begin
        if (room) state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (state == ISSUE && !skid_full)
      imem_req = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        pc <= RESET_PC;
    else if (redirect) pc <= target & ~32'h3;
    else if (fire)     pc <= pc + 32'd4;
  end

  // Kill only when a response is still owed after this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kill <= 1'b0;
    end else if (redirect
      && ((state == WAIT && !imem_rvalid) || fire)) begin
      kill <= 1'b1;
    end else if (state == WAIT && imem_rvalid) begin
      kill <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst_out   <= NOP_INST;
      pcp4_out   <= 32'h0;
    end else if (redirect) begin
      inst_valid <= 1'b0;
      inst_out   <= NOP_INST;
      pcp4_out   <= 32'h0;
    end else if (!keep) begin
      if (skid_full) begin
        inst_valid <= 1'b1;
        inst_out   <= skid_q.inst;
        pcp4_out   <= skid_q.pcp4;
      end else if (resp) begin
        inst_valid <= 1'b1;
        inst_out   <= resp_pkt.inst;
        pcp4_out   <= resp_pkt.pcp4;
      end else begin
        inst_valid <= 1'b0;
        inst_out   <= NOP_INST;
      end
    end else if (!inst_valid && resp) begin
      inst_valid <= 1'b1;
      inst_out   <= resp_pkt.inst;
      pcp4_out   <= resp_pkt.pcp4;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a
// program-order model checked every cycle.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        keep = 1'b0;
  logic [1:0]  pc_source = 2'd0;
  logic [31:0] pc_branch = 32'h0;
  logic [31:0] pc_jump = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pcp4_out;
  logic [31:0] pc_out;

  int checks = 0;
  int failures = 0;

  logic        gnt_en = 1'b1;
  logic        stray_rv = 1'b0;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] exp_pc = 32'h0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keep        (keep),
    .pc_source   (pc_source),
    .pc_branch   (pc_branch),
    .pc_jump     (pc_jump),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .pcp4_out    (pcp4_out),
    .pc_out      (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  // Memory: grant whenever enabled, answer after lat cycles.
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = (pend && cnt == 0) || stray_rv;
  assign imem_rdata  = stray_rv ? 32'hDEAD_BEEF
                     : (pend ? mem(pend_addr) : 32'h0);

  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else begin
      if (pend && cnt == 0) pend <= 1'b0;
      else if (pend)        cnt <= cnt - 1;
      if (imem_req && imem_gnt) begin
        pend      <= 1'b1;
        cnt       <= lat - 1;
        pend_addr <= imem_addr;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Every word delivered must be mem[pcp4-4], and delivered
  // words must follow program order from the last redirect.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc <= 32'h0;
    end else begin
      if (imem_req && imem_gnt)
        chk("one_outstanding", 32'(pend), 32'h0);
      if (imem_req)
        chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
      if (inst_valid)
        chk("inst_data", inst_out, mem(pcp4_out - 32'd4));
      else
        chk("nop_when_idle", inst_out, 32'h0);
      if (pc_source != 2'd0) begin
        exp_pc <= (pc_source == 2'd1 ? pc_branch : pc_jump)
                & ~32'h3;
      end else if (inst_valid && !keep) begin
        chk("prog_order", pcp4_out, exp_pc + 32'd4);
        exp_pc <= exp_pc + 32'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input logic [31:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 40) begin
      step();
      n++;
    end
    chk("issue_req", 32'(imem_req), 32'h1);
    chk("issue_addr", imem_addr, a);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    chk("valid_seen", 32'(inst_valid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pcp4", pcp4_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);

    rst_n = 1'b1;
    chk("idle_no_req", 32'(imem_req), 32'h0);
    step();
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    wait_valid(n);
    chk("latency", 32'(n), 32'd2);
    chk("s0_pcp4", pcp4_out, 32'h4);
    chk("s0_inst", inst_out, 32'hEDCB_0000);
    step();
    wait_valid(n);
    chk("s1_pcp4", pcp4_out, 32'h8);
    chk("s1_inst", inst_out, 32'hEDCF_0004);

    keep = 1'b1;
    step();
    step();
    chk("skid_no_req", 32'(imem_req), 32'h0);
    chk("keep_valid", 32'(inst_valid), 32'h1);
    chk("keep_pcp4", pcp4_out, 32'h8);
    keep = 1'b0;
    step();
    chk("s2_pcp4", pcp4_out, 32'hC);
    chk("s2_inst", inst_out, 32'hEDC3_0008);
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_addr", imem_addr, 32'hC);

    lat = 3;
    wait_issue(32'h10);
    step();
    pc_source = 2'd1;
    pc_branch = 32'h100;
    step();
    pc_source = 2'd0;
    chk("br_flush", 32'(inst_valid), 32'h0);
    wait_issue(32'h100);
    wait_valid(n);
    chk("br_pcp4", pcp4_out, 32'h104);
    chk("br_inst", inst_out, 32'hECCB_0100);

    keep = 1'b1;
    pc_source = 2'd2;
    pc_jump = 32'h203;
    step();
    pc_source = 2'd0;
    chk("j_flush_valid", 32'(inst_valid), 32'h0);
    chk("j_flush_inst", inst_out, 32'h0);
    wait_issue(32'h200);
    keep = 1'b0;
    wait_valid(n);
    chk("j_pcp4", pcp4_out, 32'h204);
    chk("j_inst", inst_out, 32'hEFCB_0200);

    pc_source = 2'd3;
    pc_jump = 32'hFFFF_FFF8;
    step();
    pc_source = 2'd0;
    wait_valid(n);
    chk("w0_pcp4", pcp4_out, 32'hFFFF_FFFC);
    chk("w0_inst", inst_out, 32'h1233_FFF8);
    step();
    wait_valid(n);
    chk("w1_pcp4", pcp4_out, 32'h0);
    chk("w1_inst", inst_out, 32'h1237_FFFC);
    wait_issue(32'h0);

    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    stray_rv = 1'b1;
    gnt_en = 1'b0;
    chk("mr_req", 32'(imem_req), 32'h0);
    chk("mr_valid", 32'(inst_valid), 32'h0);
    chk("mr_pc", pc_out, 32'h0);
    step();
    chk("stray_idle", 32'(inst_valid), 32'h0);
    chk("mr_addr", imem_addr, 32'h0);
    step();
    chk("stray_issue", 32'(inst_valid), 32'h0);
    stray_rv = 1'b0;
    gnt_en = 1'b1;
    wait_valid(n);
    chk("mr_pcp4", pcp4_out, 32'h4);
    chk("mr_inst", inst_out, 32'hEDCB_0000);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
